// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
//
// Purpose: executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU one bit per
// cycle (radix-2 shift-add multiply, restoring shift-subtract divide),
// beside the single-cycle ALU in EX. Operands are reduced to magnitudes on
// accept, the unsigned core runs WIDTH steps, and a final SIGN cycle fixes
// the sign and selects the result field.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   abort current operation (synchronous, highest priority)
//   in_valid   in   op/op1/op2 valid
//   in_ready   out  unit idle, can accept
//   op         in   RV32M funct3
//   op1        in   rs1 (multiplicand / dividend)
//   op2        in   rs2 (multiplier / divisor)
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer takes result
//   result     out  final result
//   busy       out  unit not idle

module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int OP_SIZE = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_SIZE-1:0] op,
    input  logic [WIDTH-1:0]   op1,
    input  logic [WIDTH-1:0]   op2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [OP_SIZE-1:0] OP_MUL    = OP_SIZE'(0);
    localparam logic [OP_SIZE-1:0] OP_MULH   = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_MULHSU = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_MULHU  = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] OP_DIV    = OP_SIZE'(4);
    localparam logic [OP_SIZE-1:0] OP_DIVU   = OP_SIZE'(5);
    localparam logic [OP_SIZE-1:0] OP_REM    = OP_SIZE'(6);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

    state_t                 state_q;
    logic [OP_SIZE-1:0]     op_q;
    logic                   s1_q, s2_q;     // effective operand signs
    logic [WIDTH-1:0]       a_q;            // multiplicand magnitude
    logic [WIDTH-1:0]       b_q;            // divisor magnitude
    logic [2*WIDTH-1:0]     acc_q;          // product; low half doubles as dividend/quotient
    logic [WIDTH:0]         rem_q;          // partial remainder
    logic [CW-1:0]          cnt_q;
    logic                   out_valid_q;
    logic [WIDTH-1:0]       result_q;

    // Accept-time decode
    logic               is_div_d, signed1_d, signed2_d, s1_d, s2_d;
    logic               div_zero_d, ovf_d;
    logic [WIDTH-1:0]   mag1_d, mag2_d, special_d;

    // Iteration and sign-fix datapath
    logic [WIDTH:0]     mul_sum_d;
    logic [2*WIDTH-1:0] mul_acc_d, div_acc_d, prod_fix_d;
    logic [WIDTH:0]     div_shift_d, div_trial_d, div_rem_d;
    logic               div_bit_d;
    logic [WIDTH-1:0]   quo_fix_d, rem_fix_d, result_d;

    always_comb begin
        is_div_d   = op[2];
        signed1_d  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        signed2_d  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        s1_d       = signed1_d & op1[WIDTH-1];
        s2_d       = signed2_d & op2[WIDTH-1];
        mag1_d     = s1_d ? -op1 : op1;
        mag2_d     = s2_d ? -op2 : op2;
        div_zero_d = is_div_d && (op2 == '0);
        ovf_d      = ((op == OP_DIV) || (op == OP_REM)) && (op1 == MIN_NEG) && (op2 == '1);
        special_d  = '0;
        if (div_zero_d) begin
            special_d = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : op1;
        end else if (ovf_d) begin
            special_d = (op == OP_DIV) ? op1 : '0;
        end
    end

    always_comb begin
        // Multiply: add multiplicand into the high half when the multiplier
        // LSB (sitting in the low half) is set, then shift the whole pair right.
        mul_sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_acc_d = {mul_sum_d, acc_q[WIDTH-1:1]};

        // Divide: shift next dividend bit into the remainder, trial subtract,
        // keep the difference only if it did not go negative.
        div_shift_d = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        div_trial_d = div_shift_d - {1'b0, b_q};
        div_bit_d   = ~div_trial_d[WIDTH];
        div_acc_d   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_bit_d};
        div_rem_d   = div_bit_d ? div_trial_d : div_shift_d;

        prod_fix_d  = (s1_q ^ s2_q) ? -acc_q : acc_q;
        quo_fix_d   = (s1_q ^ s2_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix_d   = s1_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

        case (op_q)
            OP_MUL:                        result_d = prod_fix_d[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_fix_d[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               result_d = quo_fix_d;
            default:                       result_d = rem_fix_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        s1_q  <= s1_d;
                        s2_q  <= s2_d;
                        a_q   <= mag1_d;
                        b_q   <= mag2_d;
                        rem_q <= '0;
                        cnt_q <= CW'(WIDTH-1);
                        acc_q <= is_div_d ? {{WIDTH{1'b0}}, mag1_d} : {{WIDTH{1'b0}}, mag2_d};
                        if (div_zero_d || ovf_d) begin
                            result_q <= special_d;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (op_q[2]) begin
                        acc_q <= div_acc_d;
                        rem_q <= div_rem_d;
                    end else begin
                        acc_q <= mul_acc_d;
                    end
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) state_q <= S_SIGN;
                end
                S_SIGN: begin
                    result_q <= result_d;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    // out_valid rises the cycle after DONE is entered
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
